radix2_divider: RTL

//   Parametrised sequential restoring divider with valid/ready handshakes on

---
 rtl/radix2_divider_pkg.sv | 12 +
 rtl/radix2_divider_div_step.sv | 24 ++
 rtl/radix2_divider.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/radix2_divider_pkg.sv
// Shared FSM state encoding for the radix-2 restoring divider.
package radix2_divider_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/radix2_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor if it fits, emit the quotient bit.
module radix2_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dsr_ext;

  always_comb begin
    shifted = {rem_in[WIDTH-1:0], next_bit};
    dsr_ext = {1'b0, divisor};
    // rem_in[WIDTH] set means the shifted value already exceeds any divisor
    q_bit   = rem_in[WIDTH] | (shifted >= dsr_ext);
    rem_out = q_bit ? (shifted - dsr_ext) : shifted;
  end

endmodule

// File: rtl/radix2_divider.sv
// Sequential signed/unsigned divider, one op in flight, result valid WIDTH+2 edges
// after accept; result held in DONE until out_ready, in_ready only while idle.
module radix2_divider
  import radix2_divider_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sm_q, sm_d;
  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
  logic [WIDTH-1:0] dsr_raw_q, dsr_raw_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic             dvd_neg, dsr_neg;

  radix2_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem_q),
    .divisor  (dsr_q),
    .next_bit (quo_q[WIDTH-1]),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sm_d          = sm_q;
    dvd_raw_d     = dvd_raw_q;
    dsr_raw_d     = dsr_raw_q;
    dsr_d         = dsr_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    dz_d          = dz_q;
    ov_d          = ov_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    dvd_neg       = sm_q & dvd_raw_q[WIDTH-1];
    dsr_neg       = sm_q & dsr_raw_q[WIDTH-1];

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_PREP;
          sm_d      = signed_mode;
          dvd_raw_d = dividend;
          dsr_raw_d = divisor;
        end
      end
      ST_PREP: begin
        // quo_q doubles as the dividend shift register; quotient bits enter at the LSB
        quo_d     = dvd_neg ? -dvd_raw_q : dvd_raw_q;
        dsr_d     = dsr_neg ? -dsr_raw_q : dsr_raw_q;
        rem_d     = '0;
        cnt_d     = '0;
        neg_quo_d = dvd_neg ^ dsr_neg;
        neg_rem_d = dvd_neg;
        dz_d      = (dsr_raw_q == '0);
        ov_d      = sm_q & (dvd_raw_q == MIN_VAL) & (dsr_raw_q == '1);
        state_d   = ST_CALC;
      end
      ST_CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        div_by_zero_d = dz_q;
        overflow_d    = ov_q;
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = dvd_raw_q;
        end else if (ov_q) begin
          quotient_d  = MIN_VAL;
          remainder_d = '0;
        end else begin
          quotient_d  = neg_quo_q ? -quo_q : quo_q;
          remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sm_q          <= 1'b0;
      dvd_raw_q     <= '0;
      dsr_raw_q     <= '0;
      dsr_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dz_q          <= 1'b0;
      ov_q          <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sm_q          <= sm_d;
      dvd_raw_q     <= dvd_raw_d;
      dsr_raw_q     <= dsr_raw_d;
      dsr_q         <= dsr_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      dz_q          <= dz_d;
      ov_q          <= ov_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule
